// File: rtl/pc_rtn_stack_pkg.sv
// Shared field positions and writeback action decode for the PC / return stack.
// Pure types and constants; no timing.
// No handshake; consumers act on the decoded action in the same cycle.
package pc_rtn_stack_pkg;

    localparam int CALL_BIT    = 29;
    localparam int TGT_LSB     = 0;
    localparam int ADDR_W_DFLT = 16;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_INC,
        ACT_JUMP,
        ACT_CALL,
        ACT_RTN
    } pc_act_e;

    // Strobe priority: return, then branch (jump or call), then increment.
    function automatic pc_act_e decode_act(input logic rtn, input logic brnch,
                                           input logic call, input logic inc);
        pc_act_e act;
        act = ACT_HOLD;
        if (rtn)
            act = ACT_RTN;
        else if (brnch)
            act = call ? ACT_CALL : ACT_JUMP;
        else if (inc)
            act = ACT_INC;
        return act;
    endfunction

endpackage

// File: rtl/pc_rtn_stack_rtn.sv
// LIFO register array holding return addresses.
// Push/pop take effect at the clock edge; top-of-stack read is combinational.
// No backpressure: push while full and pop while empty are dropped and flagged.
module rtn_stack
    import pc_rtn_stack_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DFLT,
    parameter int STK_DEPTH = 8,
    parameter int PTR_W     = $clog2(STK_DEPTH),
    parameter int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic [CNT_W-1:0]  cnt,
    output logic              full,
    output logic              empty,
    output logic              ovfl_evt,
    output logic              unfl_evt
);

    logic [ADDR_W-1:0] mem [STK_DEPTH];
    logic [CNT_W-1:0]  top_idx;
    logic              do_push;
    logic              do_pop;

    assign full     = (cnt == CNT_W'(STK_DEPTH));
    assign empty    = (cnt == '0);
    assign top_idx  = cnt - CNT_W'(1);
    assign dout     = empty ? '0 : mem[top_idx[PTR_W-1:0]];

    // Pop wins over a simultaneous push so a return never leaves a stray entry.
    assign do_pop   = pop && !empty;
    assign do_push  = push && !pop && !full;
    assign ovfl_evt = push && !pop && full;
    assign unfl_evt = pop && empty;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (do_pop)
            cnt <= cnt - CNT_W'(1);
        else if (do_push)
            cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem[cnt[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/pc_rtn_stack.sv
// Program counter with call/return stack driven by writeback strobes.
// One-cycle latency: pc and stack state update at the edge sampling the strobe.
// No backpressure; stack overflow/underflow are reported through sticky flags.
module pc_rtn_stack
    import pc_rtn_stack_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DFLT,
    parameter int          STK_DEPTH = 8,
    parameter int unsigned RST_VEC   = 0,
    parameter int          CNT_W     = $clog2(STK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              incrmnt_pc,
    input  logic              ld_brnch_addr,
    input  logic              ld_rtn_addr,
    input  logic [31:0]       crnt_instrn,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  stk_cnt,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_ovfl,
    output logic              stk_unfl
);

    pc_act_e           act;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] rtn_addr;
    logic [ADDR_W-1:0] pc_nxt;
    logic              ovfl_evt;
    logic              unfl_evt;
    logic              unused_instrn_bits;

    assign act      = decode_act(ld_rtn_addr, ld_brnch_addr,
                                 crnt_instrn[CALL_BIT], incrmnt_pc);
    assign pc_plus1 = pc + ADDR_W'(1);
    assign target   = crnt_instrn[TGT_LSB +: ADDR_W];

    assign unused_instrn_bits = &{1'b0, crnt_instrn};

    rtn_stack #(
        .ADDR_W    (ADDR_W),
        .STK_DEPTH (STK_DEPTH)
    ) u_rtn_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (act == ACT_CALL),
        .pop      (act == ACT_RTN),
        .din      (pc_plus1),
        .dout     (rtn_addr),
        .cnt      (stk_cnt),
        .full     (stk_full),
        .empty    (stk_empty),
        .ovfl_evt (ovfl_evt),
        .unfl_evt (unfl_evt)
    );

    always_comb begin
        pc_nxt = pc;
        unique case (act)
            ACT_RTN:  pc_nxt = stk_empty ? pc_plus1 : rtn_addr;
            ACT_JUMP: pc_nxt = target;
            ACT_CALL: pc_nxt = target;
            ACT_INC:  pc_nxt = pc_plus1;
            default:  pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= ADDR_W'(RST_VEC);
            stk_ovfl <= 1'b0;
            stk_unfl <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            stk_ovfl <= stk_ovfl | ovfl_evt;
            stk_unfl <= stk_unfl | unfl_evt;
        end
    end

endmodule

// File: tb/tb_pc_rtn_stack.sv
// Directed self-checking bench for pc_rtn_stack (ADDR_W=16, STK_DEPTH=8, RST_VEC=0).
module tb_pc_rtn_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        incrmnt_pc = 1'b0;
    logic        ld_brnch_addr = 1'b0;
    logic        ld_rtn_addr = 1'b0;
    logic [31:0] crnt_instrn = '0;
    logic [15:0] pc;
    logic [3:0]  stk_cnt;
    logic        stk_full;
    logic        stk_empty;
    logic        stk_ovfl;
    logic        stk_unfl;

    int errors = 0;
    int checks = 0;

    pc_rtn_stack #(.ADDR_W(16), .STK_DEPTH(8), .RST_VEC(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .incrmnt_pc    (incrmnt_pc),
        .ld_brnch_addr (ld_brnch_addr),
        .ld_rtn_addr   (ld_rtn_addr),
        .crnt_instrn   (crnt_instrn),
        .pc            (pc),
        .stk_cnt       (stk_cnt),
        .stk_full      (stk_full),
        .stk_empty     (stk_empty),
        .stk_ovfl      (stk_ovfl),
        .stk_unfl      (stk_unfl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply strobes for one clock edge, then release them; outputs are sampled #1 after the edge.
    task automatic cyc(input logic inc, input logic br, input logic rt,
                       input logic [31:0] ins, input logic rs = 1'b0);
        incrmnt_pc    = inc;
        ld_brnch_addr = br;
        ld_rtn_addr   = rt;
        crnt_instrn   = ins;
        rst           = rs;
        @(posedge clk);
        #1;
        incrmnt_pc    = 1'b0;
        ld_brnch_addr = 1'b0;
        ld_rtn_addr   = 1'b0;
        crnt_instrn   = '0;
        rst           = 1'b0;
    endtask

    task automatic jump(input logic [15:0] a);
        cyc(1'b0, 1'b1, 1'b0, {16'h0000, a});
    endtask

    task automatic call(input logic [15:0] a);
        cyc(1'b0, 1'b1, 1'b0, {16'h2000, a});
    endtask

    task automatic ret();
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_pc", pc, 0);
        check("rst_cnt", stk_cnt, 0);
        check("rst_empty", stk_empty, 1);
        check("rst_full", stk_full, 0);
        check("rst_ovfl", stk_ovfl, 0);
        check("rst_unfl", stk_unfl, 0);

        // Increment sequence and reset overriding increment
        cyc(1'b1, 1'b0, 1'b0, 32'h0); check("inc1", pc, 1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0); check("inc2", pc, 2);
        cyc(1'b1, 1'b0, 1'b0, 32'h0); check("inc3", pc, 3);
        check("inc_empty", stk_empty, 1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); check("hold_pc", pc, 3);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); check("rst_over_inc", pc, 0);

        // Single call / return
        jump(16'h0010); check("jump_10", pc, 16'h0010);
        call(16'h0040); check("call_pc", pc, 16'h0040);
        check("call_cnt", stk_cnt, 1);
        check("call_empty", stk_empty, 0);
        ret(); check("ret_pc", pc, 16'h0011);
        check("ret_cnt", stk_cnt, 0);
        check("ret_empty", stk_empty, 1);

        // Nested calls from pc=5: pushes 6, 0x101, 0x201
        jump(16'h0005);
        call(16'h0100); call(16'h0200); call(16'h0300);
        check("nest_pc", pc, 16'h0300);
        check("nest_cnt", stk_cnt, 3);
        ret(); check("nest_ret1", pc, 16'h0201);
        ret(); check("nest_ret2", pc, 16'h0101);
        ret(); check("nest_ret3", pc, 16'h0006);
        check("nest_empty", stk_empty, 1);

        // Fill to depth, overflow, then unwind
        jump(16'h0A00);
        for (int i = 0; i < 8; i++) call(16'h1000 + 16'(i * 16));
        check("fill_cnt", stk_cnt, 8);
        check("fill_full", stk_full, 1);
        check("fill_ovfl", stk_ovfl, 0);
        call(16'h1080);
        check("ovfl_pc", pc, 16'h1080);
        check("ovfl_flag", stk_ovfl, 1);
        check("ovfl_cnt", stk_cnt, 8);
        for (int k = 0; k < 8; k++) begin
            ret();
            check($sformatf("unwind_pc%0d", k), pc,
                  (k < 7) ? 32'(16'h1000 + 16'((6 - k) * 16) + 16'h1) : 32'h0A01);
            check($sformatf("unwind_cnt%0d", k), stk_cnt, 7 - k);
        end
        check("unwind_empty", stk_empty, 1);
        check("ovfl_sticky", stk_ovfl, 1);

        // Underflow and sticky behaviour
        jump(16'h0022);
        ret(); check("unfl_pc", pc, 16'h0023);
        check("unfl_flag", stk_unfl, 1);
        check("unfl_cnt", stk_cnt, 0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0); check("unfl_sticky_pc", pc, 16'h0024);
        check("unfl_sticky", stk_unfl, 1);

        // Return together with call: pop only
        call(16'h0050); call(16'h0060);
        check("pre_both_cnt", stk_cnt, 2);
        cyc(1'b0, 1'b1, 1'b1, 32'h2000_0070);
        check("both_pc", pc, 16'h0051);
        check("both_cnt", stk_cnt, 1);

        // Load wins over simultaneous increment
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0777); check("ld_over_inc", pc, 16'h0777);

        // Reset clears sticky flags and aborts an in-flight call
        cyc(1'b0, 1'b1, 1'b0, 32'h2000_0099, 1'b1);
        check("rst_call_pc", pc, 0);
        check("rst_call_cnt", stk_cnt, 0);
        check("rst_clr_ovfl", stk_ovfl, 0);
        check("rst_clr_unfl", stk_unfl, 0);

        // Wraparound of increment and pushed return address
        jump(16'hFFFF);
        cyc(1'b1, 1'b0, 1'b0, 32'h0); check("wrap_inc", pc, 16'h0000);
        jump(16'hFFFF);
        call(16'h0123); check("wrap_call_pc", pc, 16'h0123);
        check("wrap_call_cnt", stk_cnt, 1);
        ret(); check("wrap_ret", pc, 16'h0000);
        check("wrap_empty", stk_empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
